// File: rtl/mux_arb_pkg.sv
// Shared types and round-robin pick function for mux_rr_arbiter.
// Optional per-requester grant counters are enabled by defining MUX_ARB_STATS_EN.
package mux_arb_pkg;

   localparam int NREQ  = 4;
   localparam int SEL_W = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   typedef struct packed {
      logic             found;
      logic [SEL_W-1:0] idx;
   } pick_t;

   // Search starts one past the last winner and wraps, so the last winner is checked last.
   function automatic pick_t rr_pick(input logic [NREQ-1:0] req, input logic [SEL_W-1:0] last);
      pick_t            p;
      logic [SEL_W-1:0] cand;
      p.found = 1'b0;
      p.idx   = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = last + SEL_W'(k);
         if (!p.found && req[cand]) begin
            p.found = 1'b1;
            p.idx   = cand;
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/mux4_sel.sv
// Combinational 4:1 data mux used by mux_rr_arbiter (no optional features here).
module mux4_sel
   import mux_arb_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [SEL_W-1:0] sel,
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic [WIDTH-1:0] in3,
   output logic [WIDTH-1:0] y
);

   always_comb begin
      y = in0;
      unique case (sel)
         2'd0: y = in0;
         2'd1: y = in1;
         2'd2: y = in2;
         2'd3: y = in3;
      endcase
   end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux among four requesters, with a registered valid/ready output.
// Defining MUX_ARB_STATS_EN adds cnt_clr and gnt_cnt (per-requester accept counters).
module mux_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NREQ-1:0]    req,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   input  logic [WIDTH-1:0]   C,
   input  logic [WIDTH-1:0]   D,
   input  logic               out_ready,
   output logic [NREQ-1:0]    gnt,
   output logic [SEL_W-1:0]   sel,
   output logic [WIDTH-1:0]   out,
   output logic               out_valid,
`ifdef MUX_ARB_STATS_EN
   input  logic               cnt_clr,
   output logic [NREQ*CNT_W-1:0] gnt_cnt,
`endif
   output state_t             dbg_state
);

   // Handshake: a word transfers on any rising edge where out_valid && out_ready;
   // out, sel and gnt are stable while out_valid && !out_ready.

   state_t           state_q, state_d;
   logic [SEL_W-1:0] last_q, last_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [NREQ-1:0]  gnt_q, gnt_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] mux_data;
   logic             arb_en;
   pick_t            pick;

   // Arbitration happens when idle, or when the current word is being accepted.
   assign arb_en = (state_q == IDLE) || out_ready;
   assign pick   = rr_pick(req, last_q);
   assign sel_d  = (arb_en && pick.found) ? pick.idx : sel_q;

   mux4_sel #(.WIDTH(WIDTH)) u_mux (
      .sel (sel_d),
      .in0 (A),
      .in1 (B),
      .in2 (C),
      .in3 (D),
      .y   (mux_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         last_q      <= SEL_W'(NREQ - 1);
         sel_q       <= '0;
         gnt_q       <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         sel_q       <= sel_d;
         gnt_q       <= gnt_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      if (arb_en) begin
         if (pick.found) begin
            state_d = GRANT;
            last_d  = pick.idx;
         end else begin
            state_d = IDLE;
         end
      end
   end

   always_comb begin
      gnt_d       = gnt_q;
      out_d       = out_q;
      out_valid_d = out_valid_q;
      if (arb_en) begin
         if (pick.found) begin
            gnt_d       = NREQ'(1) << pick.idx;
            out_d       = mux_data;
            out_valid_d = 1'b1;
         end else begin
            gnt_d       = '0;
            out_valid_d = 1'b0;
         end
      end
   end

   assign gnt       = gnt_q;
   assign sel       = sel_q;
   assign out       = out_q;
   assign out_valid = out_valid_q;
   assign dbg_state = state_q;

`ifdef MUX_ARB_STATS_EN
   logic [NREQ-1:0][CNT_W-1:0] cnt_q, cnt_d;

   // Clear wins over a same-edge accept.
   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         cnt_d[i] = cnt_clr ? '0 : cnt_q[i] + CNT_W'(gnt_q[i] & out_ready);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign gnt_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed self-checking bench for mux_rr_arbiter; stats checks compile in when MUX_ARB_STATS_EN is defined.
module tb_mux_rr_arbiter;
   import mux_arb_pkg::*;

   localparam int W = 4;

   logic         clk;
   logic         rst_n;
   logic [3:0]   req;
   logic [W-1:0] A, B, C, D;
   logic         out_ready;
   logic [3:0]   gnt;
   logic [1:0]   sel;
   logic [W-1:0] out;
   logic         out_valid;
   state_t       dbg_state;
   int           n_checks;
   int           n_fail;
`ifdef MUX_ARB_STATS_EN
   logic         cnt_clr;
   logic [31:0]  gnt_cnt;
   logic [7:0]   gnt_cnt_s;
   state_t       dbg_state_s;
   logic [3:0]   gnt_s;
   logic [1:0]   sel_s;
   logic [W-1:0] out_s;
   logic         out_valid_s;
`endif

   mux_rr_arbiter #(.WIDTH(W), .CNT_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .A         (A),
      .B         (B),
      .C         (C),
      .D         (D),
      .out_ready (out_ready),
      .gnt       (gnt),
      .sel       (sel),
      .out       (out),
      .out_valid (out_valid),
`ifdef MUX_ARB_STATS_EN
      .cnt_clr   (cnt_clr),
      .gnt_cnt   (gnt_cnt),
`endif
      .dbg_state (dbg_state)
   );

`ifdef MUX_ARB_STATS_EN
   mux_rr_arbiter #(.WIDTH(W), .CNT_W(2)) dut_small (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .A         (A),
      .B         (B),
      .C         (C),
      .D         (D),
      .out_ready (out_ready),
      .gnt       (gnt_s),
      .sel       (sel_s),
      .out       (out_s),
      .out_valid (out_valid_s),
      .cnt_clr   (cnt_clr),
      .gnt_cnt   (gnt_cnt_s),
      .dbg_state (dbg_state_s)
   );
`endif

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req = 4'b1111;
      out_ready = 1'b1;
      step();
      step();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
      n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
      n_checks++; if (sel !== 2'b00) begin n_fail++; $display("FAIL reset_sel got=%b exp=00", sel); end
      n_checks++; if (out !== 4'd0) begin n_fail++; $display("FAIL reset_out got=%0d exp=0", out); end
      n_checks++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state got=%0d exp=IDLE", dbg_state); end
`ifdef MUX_ARB_STATS_EN
      n_checks++; if (gnt_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_cnt got=%h exp=0", gnt_cnt); end
`endif
      req = 4'b0000;
      rst_n = 1'b1;
      step();
      step();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid got=%b exp=0", out_valid); end
      n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL idle_gnt got=%b exp=0000", gnt); end
   endtask

   task automatic test_single();
      req = 4'b0100;
      out_ready = 1'b1;
      step();
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got=%b exp=1", out_valid); end
      n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL single_gnt got=%b exp=0100", gnt); end
      n_checks++; if (sel !== 2'b10) begin n_fail++; $display("FAIL single_sel got=%b exp=10", sel); end
      n_checks++; if (out !== 4'd15) begin n_fail++; $display("FAIL single_out got=%0d exp=15", out); end
      req = 4'b0000;
      step();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drop got=%b exp=0", out_valid); end
      n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL single_gnt0 got=%b exp=0000", gnt); end
      n_checks++; if (sel !== 2'b10 || out !== 4'd15) begin n_fail++; $display("FAIL single_retain got=sel%b/out%0d exp=sel10/out15", sel, out); end
   endtask

   task automatic test_fairness();
      logic [3:0]   exp_g [5];
      logic [W-1:0] exp_o [5];
      exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      exp_o = '{4'd5, 4'd9, 4'd15, 4'd2, 4'd5};
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      req = 4'b1111;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         n_checks++;
         if (out_valid !== 1'b1 || gnt !== exp_g[i] || out !== exp_o[i]) begin
            n_fail++;
            $display("FAIL fair_%0d got=v%b/g%b/o%0d exp=v1/g%b/o%0d", i, out_valid, gnt, out, exp_g[i], exp_o[i]);
         end
      end
      req = 4'b0000;
      step();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fair_end got=%b exp=0", out_valid); end
   endtask

   task automatic test_backpressure();
      req = 4'b0010;
      out_ready = 1'b0;
      step();
      n_checks++; if (gnt !== 4'b0010 || out !== 4'd9) begin n_fail++; $display("FAIL bp_grant got=g%b/o%0d exp=g0010/o9", gnt, out); end
      B = 4'd3;
      req = 4'b1010;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++;
         if (out_valid !== 1'b1 || gnt !== 4'b0010 || out !== 4'd9) begin
            n_fail++;
            $display("FAIL bp_hold_%0d got=v%b/g%b/o%0d exp=v1/g0010/o9", i, out_valid, gnt, out);
         end
      end
      out_ready = 1'b1;
      req = 4'b1000;
      step();
      n_checks++; if (out_valid !== 1'b1 || gnt !== 4'b1000 || out !== 4'd2) begin n_fail++; $display("FAIL bp_next got=v%b/g%b/o%0d exp=v1/g1000/o2", out_valid, gnt, out); end
      B = 4'd9;
      req = 4'b0000;
      step();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_end got=%b exp=0", out_valid); end
   endtask

   task automatic test_back_to_back();
      req = 4'b0100;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++;
         if (out_valid !== 1'b1 || gnt !== 4'b0100 || out !== 4'd15) begin
            n_fail++;
            $display("FAIL lone_%0d got=v%b/g%b/o%0d exp=v1/g0100/o15", i, out_valid, gnt, out);
         end
      end
      req = 4'b0000;
      step();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lone_end got=%b exp=0", out_valid); end
   endtask

   task automatic test_reset_midop();
      req = 4'b0001;
      out_ready = 1'b0;
      step();
      n_checks++; if (out_valid !== 1'b1 || gnt !== 4'b0001) begin n_fail++; $display("FAIL mid_grant got=v%b/g%b exp=v1/g0001", out_valid, gnt); end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++; if (out_valid !== 1'b0 || gnt !== 4'b0000) begin n_fail++; $display("FAIL mid_async got=v%b/g%b exp=v0/g0000", out_valid, gnt); end
      rst_n = 1'b1;
      req = 4'b1001;
      out_ready = 1'b1;
      step();
      n_checks++; if (gnt !== 4'b0001 || out !== 4'd5) begin n_fail++; $display("FAIL mid_first got=g%b/o%0d exp=g0001/o5", gnt, out); end
      req = 4'b0000;
      step();
      step();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_end got=%b exp=0", out_valid); end
   endtask

`ifdef MUX_ARB_STATS_EN
   task automatic test_stats();
      out_ready = 1'b1;
      req = 4'b0000;
      cnt_clr = 1'b1;
      step();
      cnt_clr = 1'b0;
      n_checks++; if (gnt_cnt !== 32'd0) begin n_fail++; $display("FAIL st_clr got=%h exp=0", gnt_cnt); end
      req = 4'b0100;
      step();
      step();
      step();
      req = 4'b0001;
      step();
      req = 4'b0000;
      step();
      n_checks++; if (gnt_cnt[23:16] !== 8'd3) begin n_fail++; $display("FAIL st_c got=%0d exp=3", gnt_cnt[23:16]); end
      n_checks++; if (gnt_cnt[7:0] !== 8'd1) begin n_fail++; $display("FAIL st_a got=%0d exp=1", gnt_cnt[7:0]); end
      n_checks++; if (gnt_cnt[15:8] !== 8'd0 || gnt_cnt[31:24] !== 8'd0) begin n_fail++; $display("FAIL st_bd got=%h exp=00", gnt_cnt); end
      req = 4'b0001;
      step();
      req = 4'b0000;
      cnt_clr = 1'b1;
      step();
      cnt_clr = 1'b0;
      n_checks++; if (gnt_cnt !== 32'd0) begin n_fail++; $display("FAIL st_clr_pri got=%h exp=0", gnt_cnt); end
      cnt_clr = 1'b1;
      step();
      cnt_clr = 1'b0;
      req = 4'b1000;
      for (int i = 0; i < 5; i++) step();
      req = 4'b0000;
      step();
      n_checks++; if (gnt_cnt[31:24] !== 8'd5) begin n_fail++; $display("FAIL st_d8 got=%0d exp=5", gnt_cnt[31:24]); end
      n_checks++; if (gnt_cnt_s[7:6] !== 2'd1) begin n_fail++; $display("FAIL st_d2_wrap got=%0d exp=1", gnt_cnt_s[7:6]); end
   endtask
`endif

   initial begin
      n_checks = 0;
      n_fail = 0;
      rst_n = 1'b0;
      req = 4'b0000;
      out_ready = 1'b0;
      A = 4'd5;
      B = 4'd9;
      C = 4'd15;
      D = 4'd2;
`ifdef MUX_ARB_STATS_EN
      cnt_clr = 1'b0;
`endif
      test_reset();
      test_single();
      test_fairness();
      test_backpressure();
      test_back_to_back();
      test_reset_midop();
`ifdef MUX_ARB_STATS_EN
      test_stats();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
